reg_file_arbiter: RTL and testbench

- Shares the single-port register file between two requesters: port 0 is the system controller and port 1 is a secondary configuration/debug master.
- Arbitrates between the ports round-robin and drives the register file with registered WrEn/RdEn/Address/WrData.
- Routes RdData back to the requester that issued the read, and flags a read as failed if RdData_Valid never arrives.
- Blocks port 1 from writing the protected low addresses, which hold the ALU operands and UART/clock-divider config.

---
 rtl/reg_file_arbiter_pkg.sv | 21 ++
 rtl/reg_file_arbiter_rr_arb2.sv | 35 +++
 rtl/reg_file_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_reg_file_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_arbiter_pkg.sv
// Shared types and defaults for the register-file arbiter and its round-robin picker.
package reg_file_arbiter_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned TIMEOUT_DEF    = 15;
    localparam int unsigned LOCK_BOUND_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

    // Width of a saturating counter that must be able to hold the value t.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/reg_file_arbiter_rr_arb2.sv
// Two-requester round-robin picker; remembers the last winner so contention alternates.
module reg_file_arbiter_rr_arb2
    import reg_file_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    input  logic       i_req_0,
    input  logic       i_req_1,
    input  logic       i_adv,
    output logic [1:0] o_sel_c
);

    logic r_last_gnt;

    // One-hot select; on contention the port that did not win last time goes first.
    always_comb begin
        o_sel_c = 2'b00;
        if (i_req_0 && i_req_1) begin
            o_sel_c = r_last_gnt ? 2'b01 : 2'b10;
        end else if (i_req_0) begin
            o_sel_c = 2'b01;
        end else if (i_req_1) begin
            o_sel_c = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_last_gnt <= 1'b1;
        end else if (i_adv && (i_req_0 || i_req_1)) begin
            r_last_gnt <= o_sel_c[1];
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares the single-port register file between the system controller (port 0)
// and the config/debug master (port 1); port 1 may not write the protected low addresses.
module reg_file_arbiter
    import reg_file_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
    parameter int unsigned LOCK_BOUND = LOCK_BOUND_DEF
)(
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  req_0,
    input  logic                  req_1,
    input  logic                  we_0,
    input  logic                  we_1,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic                  gnt_0,
    output logic                  gnt_1,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  rvalid_0,
    output logic                  rvalid_1,
    output logic                  err_0,
    output logic                  err_1,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid
);

    localparam int unsigned CNT_W  = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    arb_state_t            r_state, w_state_nxt;
    logic                  r_owner, w_owner_nxt;
    logic                  r_we, w_we_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]            r_gnt, w_gnt_nxt;
    logic [1:0]            r_rvalid, w_rvalid_nxt;
    logic [1:0]            r_err, w_err_nxt;
    logic [DATA_WIDTH-1:0] r_rdata0, w_rdata0_nxt;
    logic [DATA_WIDTH-1:0] r_rdata1, w_rdata1_nxt;
    logic                  r_wren, w_wren_nxt;
    logic                  r_rden, w_rden_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wrdata, w_wrdata_nxt;

    logic [1:0]            w_sel;
    logic                  w_adv;
    logic                  w_sel_port;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_sel_locked;
    logic [DATA_WIDTH-1:0] w_resp_data;
    logic                  w_resp_go;
    logic                  w_resp_err;

    reg_file_arbiter_rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .RST     (RST),
        .i_req_0 (req_0),
        .i_req_1 (req_1),
        .i_adv   (w_adv),
        .o_sel_c (w_sel)
    );

    // Fields of whichever port the picker selected this cycle.
    always_comb begin
        w_sel_port   = w_sel[1];
        w_sel_we     = w_sel[1] ? we_1    : we_0;
        w_sel_addr   = w_sel[1] ? addr_1  : addr_0;
        w_sel_wdata  = w_sel[1] ? wdata_1 : wdata_0;
        w_sel_locked = w_sel[1] && (32'(w_sel_addr) < LOCK_BOUND);
    end

    // Counter saturates at TIMEOUT; the read aborts once TIMEOUT cycles were spent waiting.
    always_comb begin
        w_cnt_inc   = (r_cnt >= TO_VAL) ? r_cnt : r_cnt + CNT_W'(1);
        w_resp_go   = 1'b0;
        w_resp_err  = 1'b0;
        w_resp_data = '0;
        if (RdData_Valid) begin
            w_resp_go   = 1'b1;
            w_resp_data = RdData;
        end else if (w_cnt_inc >= TO_VAL) begin
            w_resp_go   = 1'b1;
            w_resp_err  = 1'b1;
        end
    end

    // Next state and next registered outputs; outputs for a state are loaded on entry to it.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_we_nxt     = r_we;
        w_cnt_nxt    = r_cnt;
        w_adv        = 1'b0;
        w_gnt_nxt    = 2'b00;
        w_rvalid_nxt = 2'b00;
        w_err_nxt    = 2'b00;
        w_rdata0_nxt = r_rdata0;
        w_rdata1_nxt = r_rdata1;
        w_wren_nxt   = 1'b0;
        w_rden_nxt   = 1'b0;
        w_addr_nxt   = r_addr;
        w_wrdata_nxt = r_wrdata;

        unique case (r_state)
            ST_IDLE: begin
                if (w_sel != 2'b00) begin
                    w_adv                 = 1'b1;
                    w_owner_nxt           = w_sel_port;
                    w_we_nxt              = w_sel_we;
                    w_addr_nxt            = w_sel_addr;
                    w_gnt_nxt[w_sel_port] = 1'b1;
                    w_state_nxt           = ST_ISSUE;
                    if (!w_sel_we) begin
                        w_rden_nxt = 1'b1;
                    end else if (w_sel_locked) begin
                        w_err_nxt[1] = 1'b1;
                    end else begin
                        w_wren_nxt   = 1'b1;
                        w_wrdata_nxt = w_sel_wdata;
                    end
                end
            end

            ST_ISSUE: begin
                if (r_we) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_resp_go) begin
                    w_state_nxt            = ST_RESP;
                    w_rvalid_nxt[r_owner]  = 1'b1;
                    w_err_nxt[r_owner]     = w_resp_err;
                    if (r_owner) begin
                        w_rdata1_nxt = w_resp_data;
                    end else begin
                        w_rdata0_nxt = w_resp_data;
                    end
                end
            end

            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state  <= ST_IDLE;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_cnt    <= '0;
            r_gnt    <= 2'b00;
            r_rvalid <= 2'b00;
            r_err    <= 2'b00;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_wren   <= 1'b0;
            r_rden   <= 1'b0;
            r_addr   <= '0;
            r_wrdata <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_we     <= w_we_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gnt    <= w_gnt_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_err    <= w_err_nxt;
            r_rdata0 <= w_rdata0_nxt;
            r_rdata1 <= w_rdata1_nxt;
            r_wren   <= w_wren_nxt;
            r_rden   <= w_rden_nxt;
            r_addr   <= w_addr_nxt;
            r_wrdata <= w_wrdata_nxt;
        end
    end

    assign gnt_0    = r_gnt[0];
    assign gnt_1    = r_gnt[1];
    assign rvalid_0 = r_rvalid[0];
    assign rvalid_1 = r_rvalid[1];
    assign err_0    = r_err[0];
    assign err_1    = r_err[1];
    assign rdata_0  = r_rdata0;
    assign rdata_1  = r_rdata1;
    assign WrEn     = r_wren;
    assign RdEn     = r_rden;
    assign Address  = r_addr;
    assign WrData   = r_wrdata;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Randomized bench for reg_file_arbiter against a transaction-schedule reference model.
module tb_reg_file_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned TO = 15;
    localparam int unsigned LB = 4;
    localparam int NCYC = 2000;
    localparam int MAXC = NCYC + 40;

    logic          clk;
    logic          RST;
    logic          req_0, req_1, we_0, we_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;
    logic          gnt_0, gnt_1, rvalid_0, rvalid_1, err_0, err_1;
    logic [DW-1:0] rdata_0, rdata_1;
    logic          WrEn, RdEn;
    logic [AW-1:0] Address;
    logic [DW-1:0] WrData;
    logic [DW-1:0] RdData;
    logic          RdData_Valid;

    reg_file_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO),
        .LOCK_BOUND (LB)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .req_0        (req_0),
        .req_1        (req_1),
        .we_0         (we_0),
        .we_1         (we_1),
        .addr_0       (addr_0),
        .addr_1       (addr_1),
        .wdata_0      (wdata_0),
        .wdata_1      (wdata_1),
        .gnt_0        (gnt_0),
        .gnt_1        (gnt_1),
        .rdata_0      (rdata_0),
        .rdata_1      (rdata_1),
        .rvalid_0     (rvalid_0),
        .rvalid_1     (rvalid_1),
        .err_0        (err_0),
        .err_1        (err_1),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Expected per-cycle events, filled in by the schedule model.
    logic [1:0]    e_gnt  [MAXC];
    logic [1:0]    e_rv   [MAXC];
    logic [1:0]    e_err  [MAXC];
    logic          e_wren [MAXC];
    logic          e_rden [MAXC];
    logic [AW-1:0] e_addr [MAXC];
    logic [DW-1:0] e_wdat [MAXC];
    logic [DW-1:0] e_rd   [MAXC];

    initial begin
        int p, d, resp, last, next_sample, rdv_cyc, rw_lo, rw_hi;
        logic [DW-1:0] rdv_val;
        logic          pend  [2];
        logic          pwe   [2];
        logic [AW-1:0] paddr [2];
        logic [DW-1:0] pwd   [2];
        logic [DW-1:0] hold_rd [2];
        logic          got;

        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < MAXC; i++) begin
            e_gnt[i] = 2'b00; e_rv[i] = 2'b00; e_err[i] = 2'b00;
            e_wren[i] = 1'b0; e_rden[i] = 1'b0;
            e_addr[i] = '0; e_wdat[i] = '0; e_rd[i] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pwd[i] = '0; hold_rd[i] = '0;
        end
        last = 1; next_sample = 0; rdv_cyc = -1; rw_lo = -1; rw_hi = -2; rdv_val = '0;

        RST = 1'b0;
        req_0 = 1'b0; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
        RdData = '0; RdData_Valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset_ctrl", 32'({gnt_1, gnt_0, rvalid_1, rvalid_0, err_1, err_0, WrEn, RdEn}), 32'd0);
        check_val("reset_data", 32'({rdata_1, rdata_0, Address, WrData}), 32'd0);
        @(negedge clk);
        RST = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            check_val("gnt",    32'({gnt_1, gnt_0}),       32'(e_gnt[c]));
            check_val("rvalid", 32'({rvalid_1, rvalid_0}), 32'(e_rv[c]));
            check_val("err",    32'({err_1, err_0}),       32'(e_err[c]));
            check_val("wren",   32'(WrEn),                 32'(e_wren[c]));
            check_val("rden",   32'(RdEn),                 32'(e_rden[c]));
            if (e_wren[c] || e_rden[c]) check_val("address", 32'(Address), 32'(e_addr[c]));
            if (e_wren[c]) check_val("wrdata", 32'(WrData), 32'(e_wdat[c]));
            for (int q = 0; q < 2; q++) if (e_rv[c][q]) hold_rd[q] = e_rd[c];
            check_val("rdata_0", 32'(rdata_0), 32'(hold_rd[0]));
            check_val("rdata_1", 32'(rdata_1), 32'(hold_rd[1]));

            // Requesters: drop on grant, then maybe raise a fresh request.
            for (int q = 0; q < 2; q++) begin
                if (e_gnt[c][q]) pend[q] = 1'b0;
                if (!pend[q] && c < NCYC - 60 && (c == 0 || $urandom_range(0, 2) == 0)) begin
                    pend[q]  = 1'b1;
                    pwe[q]   = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    paddr[q] = AW'($urandom);
                    pwd[q]   = DW'($urandom);
                end
            end
            req_0 = pend[0]; we_0 = pwe[0]; addr_0 = paddr[0]; wdata_0 = pwd[0];
            req_1 = pend[1]; we_1 = pwe[1]; addr_1 = paddr[1]; wdata_1 = pwd[1];

            // Register-file side: the scheduled response, or stray strobes outside the wait window.
            RdData = DW'($urandom);
            RdData_Valid = 1'b0;
            if (c == rdv_cyc) begin
                RdData_Valid = 1'b1;
                RdData = rdv_val;
            end else if ((c < rw_lo || c > rw_hi) && $urandom_range(0, 9) == 0) begin
                RdData_Valid = 1'b1;
            end

            // Arbiter idle this cycle: predict winner and the timing of everything it triggers.
            if (c == next_sample) begin
                if (pend[0] || pend[1]) begin
                    if (pend[0] && pend[1]) p = (last == 0) ? 1 : 0;
                    else p = pend[1] ? 1 : 0;
                    last = p;
                    e_gnt[c+1][p] = 1'b1;
                    e_addr[c+1] = paddr[p];
                    if (pwe[p]) begin
                        if (p == 1 && int'(paddr[p]) < int'(LB)) begin
                            e_err[c+1][1] = 1'b1;
                        end else begin
                            e_wren[c+1] = 1'b1;
                            e_wdat[c+1] = pwd[p];
                        end
                        next_sample = c + 2;
                    end else begin
                        e_rden[c+1] = 1'b1;
                        d = $urandom_range(0, 17);
                        rw_lo = c + 2;
                        if (d < int'(TO)) begin
                            rdv_cyc = c + 2 + d;
                            rdv_val = DW'($urandom);
                            resp = c + 3 + d;
                            e_rd[resp] = rdv_val;
                        end else begin
                            rdv_cyc = -1;
                            resp = c + 2 + int'(TO);
                            e_rd[resp] = '0;
                            e_err[resp][p] = 1'b1;
                        end
                        rw_hi = resp - 1;
                        e_rv[resp][p] = 1'b1;
                        next_sample = resp + 1;
                    end
                end else begin
                    next_sample = c + 1;
                end
            end
        end

        // Reset in the middle of a port-0 read.
        req_0 = 1'b0; req_1 = 1'b0; RdData_Valid = 1'b0;
        @(posedge clk);
        #1;
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = AW'(9);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk);
            #1;
            got = gnt_0 | gnt_1;
        end
        check_val("mid_gnt_seen", 32'(got), 32'd1);
        check_val("mid_gnt",      32'({gnt_1, gnt_0}), 32'd1);
        check_val("mid_rden",     32'({RdEn, Address}), 32'({1'b1, 4'd9}));
        req_0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        RST = 1'b0;
        #1;
        check_val("mid_rst_ctrl", 32'({gnt_1, gnt_0, rvalid_1, rvalid_0, err_1, err_0, WrEn, RdEn}), 32'd0);
        check_val("mid_rst_data", 32'({rdata_1, rdata_0, Address, WrData}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        RST = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check_val("post_rst_quiet", 32'({gnt_1, gnt_0, rvalid_1, rvalid_0, err_1, err_0, WrEn, RdEn}), 32'd0);
            check_val("post_rst_rdata", 32'({rdata_1, rdata_0}), 32'd0);
            RdData_Valid = (k == 2);
            RdData = 8'hC3;
        end
        RdData_Valid = 1'b0;

        // First contention after reset goes to port 0, then port 1.
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = AW'(6); wdata_0 = 8'h5A;
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = AW'(7); wdata_1 = 8'h11;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk);
            #1;
            got = gnt_0 | gnt_1;
        end
        check_val("cont_gnt_seen", 32'(got), 32'd1);
        check_val("cont_first",    32'({gnt_1, gnt_0}), 32'd1);
        check_val("cont_first_wr", 32'({WrEn, Address, WrData}), 32'({1'b1, 4'd6, 8'h5A}));
        req_0 = 1'b0;
        @(posedge clk);
        #1;
        check_val("cont_gap", 32'({gnt_1, gnt_0, WrEn}), 32'd0);
        @(posedge clk);
        #1;
        check_val("cont_second",    32'({gnt_1, gnt_0}), 32'd2);
        check_val("cont_second_wr", 32'({WrEn, Address, WrData}), 32'({1'b1, 4'd7, 8'h11}));
        req_1 = 1'b0;
        @(posedge clk);
        #1;
        check_val("cont_idle", 32'({gnt_1, gnt_0, WrEn, RdEn}), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
